data_detransposer: RTL

// - Downstream companion of data_transposer. Reads a bit-plane block out of an MVU data RAM through the

---
 rtl/data_detransposer_pkg.sv | 43 ++++
 rtl/data_detransposer_if.sv | 24 ++
 rtl/data_detransposer_plane_buf.sv | 41 ++++
 rtl/data_detransposer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/data_detransposer_pkg.sv
// Shared types, sizes and helpers for the MVU readback path.
// Sizes cover one MVU data bank and one block of up to 16 bit-planes.
package data_detransposer_pkg;

    localparam int DT_NUM_WORDS  = 64;   // lanes per bit-plane word
    localparam int DT_XLEN       = 32;   // host word width
    localparam int DT_ADDR_LEN   = 10;   // MVU data RAM address width
    localparam int DT_DATA_LEN   = 64;   // MVU data RAM word width (one bit per lane)
    localparam int DT_MAX_PREC   = 16;   // max bit-planes per block
    localparam int MVU_RD_LAT    = 2;    // accepted read to rdc_word valid

    localparam int DT_PREC_W     = 5;                        // holds 0..DT_MAX_PREC
    localparam int DT_PLANE_W    = $clog2(DT_MAX_PREC);      // plane buffer index
    localparam int DT_K_W        = $clog2(DT_NUM_WORDS);     // lane index
    localparam int DT_SH_W       = $clog2(DT_XLEN) + 1;      // holds 0..DT_XLEN

    typedef enum logic [1:0] {DT_IDLE, DT_FETCH, DT_DRAIN} detrans_state_t;

    // Turns MSB-aligned plane bits of one lane into an XLEN word.
    // The bits are placed at the top of the word and shifted back down by
    // XLEN-prec, so an arithmetic shift gives sign extension from bit prec-1
    // and a logical shift gives zero extension. Planes beyond prec fall off.
    function automatic logic [DT_XLEN-1:0] dt_extend(
        input logic [DT_MAX_PREC-1:0] bits,
        input logic [DT_PREC_W-1:0]   prec_v,
        input logic                   is_signed_v
    );
        logic [DT_XLEN-1:0]        top_v;
        logic signed [DT_XLEN-1:0] stop_v;
        logic [DT_SH_W-1:0]        sh_v;
        logic [DT_XLEN-1:0]        res_v;
        top_v  = {bits, {(DT_XLEN-DT_MAX_PREC){1'b0}}};
        stop_v = signed'(top_v);
        sh_v   = DT_SH_W'(DT_XLEN) - DT_SH_W'(prec_v);
        if (is_signed_v) begin
            res_v = $unsigned(stop_v >>> sh_v);
        end else begin
            res_v = top_v >> sh_v;
        end
        return res_v;
    endfunction

endpackage

// File: rtl/data_detransposer_if.sv
// MVU data RAM read port plus the host-side output stream of the detransposer.
// master: the detransposer; slave: the RAM/consumer side.
interface data_detransposer_if;
    import data_detransposer_pkg::*;

    logic                   rdc_en;
    logic                   rdc_grnt;
    logic [DT_ADDR_LEN-1:0] rdc_addr;
    logic [DT_DATA_LEN-1:0] rdc_word;
    logic                   out_valid;
    logic                   out_ready;
    logic [DT_XLEN-1:0]     out_word;
    logic                   out_last;

    modport master (
        output rdc_en, rdc_addr, out_valid, out_word, out_last,
        input  rdc_grnt, rdc_word, out_ready
    );

    modport slave (
        input  rdc_en, rdc_addr, out_valid, out_word, out_last,
        output rdc_grnt, rdc_word, out_ready
    );
endinterface

// File: rtl/data_detransposer_plane_buf.sv
// Plane buffer: one RAM word per bit-plane, single write port, and a
// combinational gather of one lane's bits across all planes (plane 0 at MSB).
module detrans_plane_buf
    import data_detransposer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clr,
    input  logic                   i_we,
    input  logic [DT_PLANE_W-1:0]  i_widx,
    input  logic [DT_DATA_LEN-1:0] i_wdata,
    input  logic [DT_K_W-1:0]      i_lane,
    output logic [DT_MAX_PREC-1:0] o_bits
);

    logic [DT_DATA_LEN-1:0] r_mem [DT_MAX_PREC];

    // Plane storage: cleared on reset and at block start, written per returning plane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < DT_MAX_PREC; p++) begin
                r_mem[p] <= {DT_DATA_LEN{1'b0}};
            end
        end else if (i_clr) begin
            for (int p = 0; p < DT_MAX_PREC; p++) begin
                r_mem[p] <= {DT_DATA_LEN{1'b0}};
            end
        end else if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    // Lane gather: plane p lands at bit MAX_PREC-1-p so plane 0 is the MSB.
    always_comb begin
        o_bits = {DT_MAX_PREC{1'b0}};
        for (int p = 0; p < DT_MAX_PREC; p++) begin
            o_bits[DT_MAX_PREC-1-p] = r_mem[p][i_lane];
        end
    end

endmodule

// File: rtl/data_detransposer.sv
// Readback path of one MVU: fetches prec bit-planes from the MVU data RAM,
// then streams one reconstructed (sign/zero-extended) integer per lane.
module data_detransposer
    import data_detransposer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         prec,
    input  logic [31:0]         baddr,
    input  logic                is_signed,
    input  logic                start,
    output logic                busy,
    output logic                err,
    data_detransposer_if.master bus
);

    detrans_state_t         r_state, w_state_nxt;
    logic [DT_PREC_W-1:0]   r_prec, r_issued, r_recvd;
    logic [DT_PREC_W-1:0]   w_issued_nxt, w_recvd_nxt, w_prec_in, w_cfg_prec;
    logic [DT_ADDR_LEN-1:0] r_baddr, w_cfg_baddr, r_rdc_addr, w_rdc_addr_nxt;
    logic                   r_signed;
    logic [MVU_RD_LAT-1:0]  r_pipe;
    logic [DT_K_W-1:0]      r_k, w_k_nxt, w_lane;
    logic                   r_busy, r_err, r_rdc_en, r_out_valid, r_out_last;
    logic [DT_XLEN-1:0]     r_out_word, w_out_word_nxt;
    logic                   w_err_nxt, w_rdc_en_nxt, w_out_valid_nxt, w_out_last_nxt;
    logic                   w_load, w_clr, w_we, w_acc, w_ret, w_prec_ok;
    logic [DT_MAX_PREC-1:0] w_lane_bits;
    logic                   w_unused_bits;

    localparam logic [DT_K_W-1:0] K_LAST = DT_K_W'(DT_NUM_WORDS - 1);

    assign w_prec_in     = prec[DT_PREC_W-1:0];
    assign w_prec_ok     = (w_prec_in != {DT_PREC_W{1'b0}}) &&
                           (w_prec_in <= DT_PREC_W'(DT_MAX_PREC));
    assign w_unused_bits = ^{prec[31:DT_PREC_W], baddr[31:DT_ADDR_LEN]};
    assign w_acc         = r_rdc_en & bus.rdc_grnt;
    assign w_ret         = r_pipe[MVU_RD_LAT-1];
    assign w_we          = w_ret && (r_state == DT_FETCH) && (r_recvd < r_prec);
    // During DRAIN the gather looks one lane ahead so the next word is ready at handshake.
    assign w_lane        = (r_state == DT_DRAIN) ? (r_k + {{(DT_K_W-1){1'b0}}, 1'b1})
                                                 : {DT_K_W{1'b0}};

    detrans_plane_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_we    (w_we),
        .i_widx  (r_recvd[DT_PLANE_W-1:0]),
        .i_wdata (bus.rdc_word),
        .i_lane  (w_lane),
        .o_bits  (w_lane_bits)
    );

    // Next-state logic: start/err decode, request and return counting, output stream.
    always_comb begin
        w_state_nxt     = r_state;
        w_issued_nxt    = r_issued;
        w_recvd_nxt     = r_recvd;
        w_k_nxt         = r_k;
        w_load          = 1'b0;
        w_clr           = 1'b0;
        w_err_nxt       = 1'b0;
        w_out_valid_nxt = r_out_valid;
        w_out_word_nxt  = r_out_word;
        w_out_last_nxt  = r_out_last;
        case (r_state)
            DT_IDLE: begin
                if (start) begin
                    if (w_prec_ok) begin
                        w_state_nxt  = DT_FETCH;
                        w_issued_nxt = {DT_PREC_W{1'b0}};
                        w_recvd_nxt  = {DT_PREC_W{1'b0}};
                        w_k_nxt      = {DT_K_W{1'b0}};
                        w_load       = 1'b1;
                        w_clr        = 1'b1;
                    end else begin
                        w_err_nxt    = 1'b1;
                    end
                end else begin
                    w_state_nxt = DT_IDLE;
                end
            end
            DT_FETCH: begin
                if (w_acc) begin
                    w_issued_nxt = r_issued + {{(DT_PREC_W-1){1'b0}}, 1'b1};
                end else begin
                    w_issued_nxt = r_issued;
                end
                if (w_we) begin
                    w_recvd_nxt = r_recvd + {{(DT_PREC_W-1){1'b0}}, 1'b1};
                end else begin
                    w_recvd_nxt = r_recvd;
                end
                // All planes in: present lane 0 straight away.
                if (r_recvd == r_prec) begin
                    w_state_nxt     = DT_DRAIN;
                    w_out_valid_nxt = 1'b1;
                    w_out_word_nxt  = dt_extend(w_lane_bits, r_prec, r_signed);
                    w_out_last_nxt  = (K_LAST == {DT_K_W{1'b0}});
                end else begin
                    w_state_nxt     = DT_FETCH;
                end
            end
            DT_DRAIN: begin
                if (r_out_valid && bus.out_ready) begin
                    if (r_k == K_LAST) begin
                        w_state_nxt     = DT_IDLE;
                        w_out_valid_nxt = 1'b0;
                        w_out_last_nxt  = 1'b0;
                    end else begin
                        w_k_nxt         = w_lane;
                        w_out_word_nxt  = dt_extend(w_lane_bits, r_prec, r_signed);
                        w_out_last_nxt  = (w_lane == K_LAST);
                    end
                end else begin
                    w_state_nxt = DT_DRAIN;
                end
            end
            default: begin
                w_state_nxt     = DT_IDLE;
                w_out_valid_nxt = 1'b0;
                w_out_last_nxt  = 1'b0;
            end
        endcase
    end

    // Request port for next cycle; uses the freshly sampled config on the start cycle.
    always_comb begin
        w_cfg_prec     = w_load ? w_prec_in : r_prec;
        w_cfg_baddr    = w_load ? baddr[DT_ADDR_LEN-1:0] : r_baddr;
        w_rdc_en_nxt   = (w_state_nxt == DT_FETCH) && (w_issued_nxt < w_cfg_prec);
        w_rdc_addr_nxt = w_cfg_baddr + DT_ADDR_LEN'(w_issued_nxt);
    end

    // State, counters, latency pipe and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= DT_IDLE;
            r_prec      <= {DT_PREC_W{1'b0}};
            r_baddr     <= {DT_ADDR_LEN{1'b0}};
            r_signed    <= 1'b0;
            r_issued    <= {DT_PREC_W{1'b0}};
            r_recvd     <= {DT_PREC_W{1'b0}};
            r_pipe      <= {MVU_RD_LAT{1'b0}};
            r_k         <= {DT_K_W{1'b0}};
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_rdc_en    <= 1'b0;
            r_rdc_addr  <= {DT_ADDR_LEN{1'b0}};
            r_out_valid <= 1'b0;
            r_out_word  <= {DT_XLEN{1'b0}};
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prec      <= w_cfg_prec;
            r_baddr     <= w_cfg_baddr;
            r_signed    <= w_load ? is_signed : r_signed;
            r_issued    <= w_issued_nxt;
            r_recvd     <= w_recvd_nxt;
            r_pipe      <= {r_pipe[MVU_RD_LAT-2:0], w_acc};
            r_k         <= w_k_nxt;
            r_busy      <= (w_state_nxt != DT_IDLE);
            r_err       <= w_err_nxt;
            r_rdc_en    <= w_rdc_en_nxt;
            r_rdc_addr  <= w_rdc_addr_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_word  <= w_out_word_nxt;
            r_out_last  <= w_out_last_nxt;
        end
    end

    assign busy          = r_busy;
    assign err           = r_err;
    assign bus.rdc_en    = r_rdc_en;
    assign bus.rdc_addr  = r_rdc_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_word  = r_out_word;
    assign bus.out_last  = r_out_last;

endmodule
